// File: rtl/snn_pkg.sv
// Shared definitions for the SNN run sequencer: network command codes, idle
// bus address, the command-table entry layout and the sequencer FSM states.
package snn_pkg;

    localparam int SNN_ADDR_W  = 8;
    localparam int SNN_CMD_W   = 8;
    localparam int SNN_FLOAT_W = 16;

    // Command codes count down from all-ones so they never collide with small opcodes
    localparam logic [SNN_CMD_W-1:0] CMD_SET_DELIVERY_TIME         = {SNN_CMD_W{1'b1}};
    localparam logic [SNN_CMD_W-1:0] CMD_SET_BIAS                  = {SNN_CMD_W{1'b1}} - SNN_CMD_W'(1);
    localparam logic [SNN_CMD_W-1:0] CMD_CLEAR                     = {SNN_CMD_W{1'b1}} - SNN_CMD_W'(2);
    localparam logic [SNN_CMD_W-1:0] CMD_SET_INPUT_TRAIN_LENGTH    = {SNN_CMD_W{1'b1}} - SNN_CMD_W'(3);
    localparam logic [SNN_CMD_W-1:0] CMD_SET_INPUT_TRAIN_FREQUENCY = {SNN_CMD_W{1'b1}} - SNN_CMD_W'(4);

    localparam logic [SNN_ADDR_W-1:0] ADDR_IDLE = {SNN_ADDR_W{1'b1}};

    typedef struct packed {
        logic [SNN_ADDR_W-1:0]         addr;
        logic [SNN_CMD_W-1:0]          cmd;
        logic signed [SNN_FLOAT_W-1:0] arg;
    } snn_cmd_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NRST,
        ST_ISSUE,
        ST_WAIT,
        ST_SAMPLE
    } snn_state_e;

endpackage

// File: rtl/snn_cmd_table.sv
// Command table: DEPTH registered entries, one write port, one combinational
// read port. Contents survive reset on purpose so a loaded program persists.
module snn_cmd_table
    import snn_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int PTR_WIDTH = 6,
    parameter int ENTRY_W   = 32
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PTR_WIDTH-1:0] waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [PTR_WIDTH-1:0] raddr,
    output logic [ENTRY_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0] DEPTH_P = PTR_WIDTH'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Out-of-range indices are dropped on write and read back as zero
    always_ff @(posedge clk) begin
        if (we && (waddr < DEPTH_P)) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    assign rdata = (raddr < DEPTH_P) ? mem[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/snn_run_sequencer.sv
// Drives the spiking_neural_network_xor command bus: on start it pulses the
// network reset, streams the command table, waits a compute window, samples out.
module snn_run_sequencer
    import snn_pkg::*;
#(
    parameter int INT_WIDTH   = 8,
    parameter int FLOAT_WIDTH = 2*INT_WIDTH,
    parameter int CMD_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int IN_WIDTH    = 2,
    parameter int DEPTH       = 32,
    parameter int PTR_WIDTH   = $clog2(DEPTH+1),
    parameter int WAIT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tbl_we,
    input  logic [PTR_WIDTH-1:0]          tbl_waddr,
    input  logic [ADDR_WIDTH+CMD_WIDTH+FLOAT_WIDTH-1:0] tbl_wdata,
    input  logic [PTR_WIDTH-1:0]          tbl_len,
    input  logic [WAIT_WIDTH-1:0]         wait_cycles,
    input  logic [IN_WIDTH-1:0]           in_vec,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          result,
    output logic                          result_valid,
    output logic                          net_rst,
    output logic [ADDR_WIDTH-1:0]         net_addr,
    output logic [CMD_WIDTH-1:0]          net_cmd,
    output logic signed [FLOAT_WIDTH-1:0] net_cmd_arg,
    output logic [IN_WIDTH-1:0]           net_in,
    input  logic                          net_out
);

    localparam int ENTRY_W = ADDR_WIDTH + CMD_WIDTH + FLOAT_WIDTH;
    localparam logic [PTR_WIDTH-1:0] DEPTH_P = PTR_WIDTH'(DEPTH);

    snn_state_e             state_q, state_d;
    logic [PTR_WIDTH-1:0]   len_q, idx_q, idx_d;
    logic [WAIT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ENTRY_W-1:0]     rd_entry;
    logic                   net_rst_q;

    snn_cmd_table #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH),
        .ENTRY_W   (ENTRY_W)
    ) u_table (
        .clk   (clk),
        .we    (tbl_we && (state_q == ST_IDLE)),
        .waddr (tbl_waddr),
        .wdata (tbl_wdata),
        .raddr (idx_d),
        .rdata (rd_entry)
    );

    // The wait count is loaded at start and only runs down once WAIT is entered
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_NRST;
                    cnt_d   = wait_cycles;
                end
            end
            ST_NRST: begin
                idx_d = '0;
                if (len_q != '0) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = (cnt_q != '0) ? ST_WAIT : ST_SAMPLE;
                end
            end
            ST_ISSUE: begin
                if (idx_q == len_q - PTR_WIDTH'(1)) begin
                    state_d = (cnt_q != '0) ? ST_WAIT : ST_SAMPLE;
                end else begin
                    idx_d = idx_q + PTR_WIDTH'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q <= WAIT_WIDTH'(1)) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - WAIT_WIDTH'(1);
                end
            end
            ST_SAMPLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= 1'b0;
            result_valid <= 1'b0;
            net_rst_q    <= 1'b1;
            net_addr     <= '1;
            net_cmd      <= '0;
            net_cmd_arg  <= '0;
            net_in       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            busy         <= state_d inside {ST_NRST, ST_ISSUE, ST_WAIT};
            done         <= (state_d == ST_SAMPLE);
            result_valid <= (state_d == ST_SAMPLE);
            net_rst_q    <= (state_d == ST_NRST);
            if ((state_q == ST_IDLE) && start) begin
                len_q  <= (tbl_len > DEPTH_P) ? DEPTH_P : tbl_len;
                net_in <= in_vec;
            end
            if (state_d == ST_SAMPLE) begin
                result <= net_out;
            end
            if (state_d == ST_ISSUE) begin
                net_addr    <= rd_entry[ENTRY_W-1 -: ADDR_WIDTH];
                net_cmd     <= rd_entry[CMD_WIDTH+FLOAT_WIDTH-1 -: CMD_WIDTH];
                net_cmd_arg <= rd_entry[FLOAT_WIDTH-1:0];
            end else begin
                net_addr    <= '1;
                net_cmd     <= '0;
                net_cmd_arg <= '0;
            end
        end
    end

    assign net_rst = rst | net_rst_q;

endmodule

// File: tb/tb_snn_run_sequencer.sv
// Self-checking bench for snn_run_sequencer: each run is checked cycle by cycle
// against a trace built from a shadow copy of the command table.
module tb_snn_run_sequencer;
    import snn_pkg::*;

    localparam int DEPTH   = 32;
    localparam int PTR_W   = 6;
    localparam int WAIT_W  = 16;
    localparam int ENTRY_W = 32;
    localparam logic [ENTRY_W-1:0] IDLE_BUS = {8'hFF, 24'h000000};

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                tbl_we = 1'b0;
    logic [PTR_W-1:0]    tbl_waddr = '0;
    logic [ENTRY_W-1:0]  tbl_wdata = '0;
    logic [PTR_W-1:0]    tbl_len = '0;
    logic [WAIT_W-1:0]   wait_cycles = '0;
    logic [1:0]          in_vec = '0;
    logic                start = 1'b0;
    logic                busy, done, result, result_valid, net_rst;
    logic [7:0]          net_addr, net_cmd;
    logic signed [15:0]  net_cmd_arg;
    logic [1:0]          net_in;
    logic                net_out;
    logic                out_drive = 1'b0;

    logic [ENTRY_W-1:0]  shadow [DEPTH];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    assign net_out = out_drive;

    snn_run_sequencer #(
        .INT_WIDTH(8), .FLOAT_WIDTH(16), .CMD_WIDTH(8), .ADDR_WIDTH(8),
        .IN_WIDTH(2), .DEPTH(DEPTH), .PTR_WIDTH(PTR_W), .WAIT_WIDTH(WAIT_W)
    ) dut (
        .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr),
        .tbl_wdata(tbl_wdata), .tbl_len(tbl_len), .wait_cycles(wait_cycles),
        .in_vec(in_vec), .start(start), .busy(busy), .done(done),
        .result(result), .result_valid(result_valid), .net_rst(net_rst),
        .net_addr(net_addr), .net_cmd(net_cmd), .net_cmd_arg(net_cmd_arg),
        .net_in(net_in), .net_out(net_out)
    );

    function automatic logic [ENTRY_W-1:0] mk(input int a, input int c, input int g);
        snn_cmd_entry_t t;
        t.addr = 8'(a);
        t.cmd  = 8'(c);
        t.arg  = 16'(g);
        return t;
    endfunction

    task automatic write_entry(input int idx, input logic [ENTRY_W-1:0] e);
        @(negedge clk);
        tbl_we    = 1'b1;
        tbl_waddr = PTR_W'(idx);
        tbl_wdata = e;
        if (idx < DEPTH) shadow[idx] = e;
        @(posedge clk);
        #1 tbl_we = 1'b0;
    endtask

    // One run: cycle c is the c-th cycle after the edge that samples start.
    task automatic run(input int len, input int wt, input logic [1:0] inv,
                       input int disturb_c, input bit xor_net, input bit chain);
        int L, n;
        logic exp_res;
        logic [ENTRY_W-1:0] e;
        L = (len > DEPTH) ? DEPTH : len;
        n = 2 + L + wt;
        @(negedge clk);
        tbl_len     = PTR_W'(len);
        wait_cycles = WAIT_W'(wt);
        in_vec      = inv;
        start       = 1'b1;
        out_drive   = xor_net ? (inv[0] ^ inv[1]) : 1'($urandom);
        exp_res     = out_drive;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            e = (c >= 2 && c <= 1 + L) ? shadow[c-2] : IDLE_BUS;
            total++;
            if (net_rst !== (c == 1)) begin
                bad++; $display("FAIL net_rst cyc=%0d got=%b want=%b", c, net_rst, (c == 1));
            end
            total++;
            if ({net_addr, net_cmd, net_cmd_arg} !== e) begin
                bad++; $display("FAIL bus cyc=%0d got=%h want=%h", c, {net_addr, net_cmd, net_cmd_arg}, e);
            end
            total++;
            if (busy !== (c < n)) begin
                bad++; $display("FAIL busy cyc=%0d got=%b want=%b", c, busy, (c < n));
            end
            total++;
            if (done !== (c == n) || result_valid !== (c == n)) begin
                bad++; $display("FAIL done cyc=%0d got=%b/%b want=%b", c, done, result_valid, (c == n));
            end
            total++;
            if (net_in !== inv) begin
                bad++; $display("FAIL net_in cyc=%0d got=%b want=%b", c, net_in, inv);
            end
            if (c == n) begin
                total++;
                if (result !== exp_res) begin
                    bad++; $display("FAIL result cyc=%0d got=%b want=%b", c, result, exp_res);
                end
            end
            start  = 1'b0;
            tbl_we = 1'b0;
            if (c == 1) begin
                tbl_len     = PTR_W'($urandom);
                wait_cycles = WAIT_W'($urandom);
                in_vec      = 2'($urandom);
            end
            if (c == disturb_c) begin
                start     = 1'b1;
                tbl_we    = 1'b1;
                tbl_waddr = '0;
                tbl_wdata = ~shadow[0];
            end
            if (!xor_net) out_drive = 1'($urandom);
            if (c == n - 1) exp_res = out_drive;
            if (c == n && chain) start = 1'b1;
        end
        tbl_we = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, result, result_valid, net_rst} !== 5'b00001) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00001", {busy, done, result, result_valid, net_rst});
        end
        total++;
        if ({net_addr, net_cmd, net_cmd_arg, net_in} !== {IDLE_BUS, 2'b00}) begin
            bad++; $display("FAIL reset_bus got=%h want=%h", {net_addr, net_cmd, net_cmd_arg, net_in}, {IDLE_BUS, 2'b00});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (net_rst !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset got=%b%b want=00", net_rst, busy);
        end
    endtask

    task automatic test_load_random;
        for (int i = 0; i < DEPTH; i++) write_entry(i, ENTRY_W'($urandom));
    endtask

    task automatic test_bus_trace;
        run(3, 2, 2'b10, 0, 1'b0, 1'b0);
    endtask

    task automatic test_len_zero;
        run(0, 0, 2'b01, 0, 1'b0, 1'b0);
    endtask

    task automatic test_xor;
        int xa [22] = '{0, 1, 2, 3, 4, 0, 1, 0, 1, 2, 2, 3, 3, 4, 4, 2, 3, 4, 2, 3, 0, 1};
        int xc [22] = '{int'(CMD_SET_DELIVERY_TIME), int'(CMD_SET_DELIVERY_TIME),
                        int'(CMD_SET_BIAS), int'(CMD_SET_BIAS), int'(CMD_SET_BIAS),
                        int'(CMD_SET_INPUT_TRAIN_LENGTH), int'(CMD_SET_INPUT_TRAIN_LENGTH),
                        int'(CMD_SET_INPUT_TRAIN_FREQUENCY), int'(CMD_SET_INPUT_TRAIN_FREQUENCY),
                        0, 1, 0, 1, 2, 3, int'(CMD_SET_DELIVERY_TIME), int'(CMD_SET_DELIVERY_TIME),
                        int'(CMD_SET_DELIVERY_TIME), int'(CMD_SET_BIAS), int'(CMD_SET_BIAS),
                        int'(CMD_CLEAR), 0};
        int xg [22] = '{2, 2, -3, -3, -5, 10, 10, 3, 3, 256, -256, -256, 256, 512, 512,
                        1, 1, 1, -2, -2, 0, 0};
        logic [1:0] v;
        for (int i = 0; i < 22; i++) write_entry(i, mk(xa[i], xc[i], xg[i]));
        for (int k = 0; k < 4; k++) begin
            v = 2'(k);
            run(22, 35, v, 0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_busy_ignore;
        int extra;
        extra = 0;
        run(10, 5, 2'b01, 6, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++; $display("FAIL ignored_start got=%0d extra active cycles want=0", extra);
        end
        run(3, 1, 2'b11, 0, 1'b0, 1'b0);
    endtask

    task automatic test_abort;
        int seen;
        seen = 0;
        @(negedge clk);
        tbl_len = 6'd8; wait_cycles = 16'd4; in_vec = 2'b11; start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++;
        if ({net_addr, net_cmd, net_cmd_arg} !== shadow[5]) begin
            bad++; $display("FAIL abort_entry5 got=%h want=%h", {net_addr, net_cmd, net_cmd_arg}, shadow[5]);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, net_rst, result_valid, done} !== 4'b0100 || net_addr !== 8'hFF) begin
            bad++; $display("FAIL abort_state got=%b addr=%h want=0100 addr=ff", {busy, net_rst, result_valid, done}, net_addr);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL abort_no_result got=%0d want=0", seen);
        end
        run(6, 2, 2'b10, 0, 1'b0, 1'b0);
    endtask

    task automatic test_clamp;
        write_entry(32, ~shadow[0]);
        run(40, 3, 2'b01, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run(5, 3, 2'b01, 0, 1'b0, 1'b1);
        run(4, 0, 2'b10, 0, 1'b0, 1'b1);
        run(2, 1, 2'b11, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 3; k++) write_entry($urandom_range(0, DEPTH - 1), ENTRY_W'($urandom));
            run($urandom_range(0, 40), $urandom_range(0, 12), 2'($urandom), 0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_random();
        test_bus_trace();
        test_len_zero();
        test_xor();
        test_busy_ignore();
        test_abort();
        test_clamp();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snn_run_sequencer.md
Name: snn_run_sequencer

Overview:
- Controller that owns the command bus of `spiking_neural_network_xor`.
- Holds a writable table of (addr, cmd, cmd_arg) entries. On `start` it:
  - pulses the network reset,
  - streams the table one entry per clock,
  - idles the bus for a programmable compute window,
  - samples the network output.
- Replaces bench-driven configuration so a host or top-level FSM can run inference with a single start pulse.

Parameters:
- INT_WIDTH, 8, network integer width.
- FLOAT_WIDTH, 2*INT_WIDTH, cmd_arg width (signed).
- CMD_WIDTH, 8, command field width.
- ADDR_WIDTH, 8, neuron address width. All-ones is the bus idle value.
- IN_WIDTH, 2, network input vector width.
- DEPTH, 32, command table entries.
- PTR_WIDTH, $clog2(DEPTH+1), table index/length width.
- WAIT_WIDTH, 16, compute-window counter width.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- tbl_we  in  1  table write strobe.
- tbl_waddr  in  PTR_WIDTH  table write index.
- tbl_wdata  in  ADDR_WIDTH+CMD_WIDTH+FLOAT_WIDTH  packed entry {addr, cmd, arg}.
- tbl_len  in  PTR_WIDTH  number of entries to issue; latched at start.
- wait_cycles  in  WAIT_WIDTH  compute window length; latched at start.
- in_vec  in  IN_WIDTH  network inputs; latched at start.
- start  in  1  run request, single-cycle pulse.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse coincident with result_valid.
- result  out  1  sampled network output.
- result_valid  out  1  one-cycle pulse.
- net_rst  out  1  network reset.
- net_addr  out  ADDR_WIDTH  to network addr.
- net_cmd  out  CMD_WIDTH  to network cmd.
- net_cmd_arg  out  FLOAT_WIDTH  to network cmd_arg.
- net_in  out  IN_WIDTH  to network in.
- net_out  in  1  from network out.

Behaviour:
- Reset values (all outputs registered):
  - state IDLE, busy 0, done 0, result 0, result_valid 0.
  - net_rst 1 (`net_rst` = rst OR internal pulse).
  - net_addr all-ones, net_cmd 0, net_cmd_arg 0, net_in 0.
- Table contents are not cleared by reset.
- FSM states: IDLE -> NRST -> ISSUE -> WAIT -> SAMPLE -> IDLE.
- IDLE:
  - `start` sampled high latches tbl_len (clamped to DEPTH), wait_cycles and in_vec, sets busy, and moves to NRST.
  - `tbl_we` is honoured only in IDLE. Writes with tbl_waddr >= DEPTH are dropped.
- NRST: exactly one cycle with net_rst=1. net_in already holds the latched in_vec. Next state is ISSUE, or WAIT if len=0.
- ISSUE:
  - Entry i drives net_addr/net_cmd/net_cmd_arg during the i-th ISSUE cycle, one cycle per entry, no gaps.
  - After entry len-1, the bus returns to all-ones/0/0 and the FSM enters WAIT.
- WAIT:
  - Counter loads wait_cycles and decrements each cycle.
  - The bus stays idle for exactly wait_cycles cycles; wait_cycles=0 means zero WAIT cycles.
- SAMPLE: one cycle. result <= net_out; result_valid=1, done=1, busy=0; return to IDLE.
- Latency: start sampled at edge T.
  - net_rst high in cycle T+1.
  - Entries occupy T+2 .. T+1+L.
  - Result pulse occurs at cycle T+2+L+W.
- `start` while busy is ignored, not queued.
- `start` asserted in the SAMPLE cycle is ignored; `start` in the following IDLE cycle is accepted, so back-to-back runs are possible.
- `rst` mid-run aborts immediately: outputs take their reset values next cycle and no result_valid is produced.
- net_in holds its latched value after the run until the next accepted start.
- result holds its value until the next SAMPLE.

Decomposition:
- Package `snn_pkg` holds:
  - the command constants CMD_SET_DELIVERY_TIME=all-ones, CMD_SET_BIAS=all-ones-1, CMD_CLEAR=all-ones-2, CMD_SET_INPUT_TRAIN_LENGTH=all-ones-3, CMD_SET_INPUT_TRAIN_FREQUENCY=all-ones-4 (relative to CMD_WIDTH);
  - the ADDR_IDLE constant;
  - the packed struct snn_cmd_entry_t {addr, cmd, arg};
  - the FSM state enum.
- Sub-module `snn_cmd_table`: DEPTH x entry register array with one write port and one asynchronous read port.

Test Plan:
- XOR run: load the 22-entry XOR configuration (the last two entries are CLEAR and cmd 0 to addr 1), len=22, W=35, in_vec=00/01/10/11 -> result 0/1/1/0, result_valid at T+59.
- Bus trace: len=3, W=2 -> net_rst high only at T+1; entries 0,1,2 appear on net_addr at T+2..T+4; net_addr=8'hFF at T+5..T+6; done at T+7.
- len=0, W=0 -> NRST at T+1, done at T+2, no non-idle bus cycle.
- Start while busy, and tbl_we at index 0 mid-run -> both ignored; entry 0 unchanged on the next run; exactly one done per accepted start.
- rst asserted during ISSUE entry 5 -> next cycle busy=0, net_addr=all-ones, net_rst=1, no result_valid; a subsequent start completes normally.
- tbl_len=40 with DEPTH=32 -> exactly 32 issue cycles. A write with waddr=32 is dropped.
